// File: rtl/aes_pkg.sv
// Shared AES types, sizes and byte-index helper for the round datapath.
package aes_pkg;

   typedef logic [127:0] aes_state_t;
   typedef logic [7:0]   aes_byte_t;

   localparam int unsigned AES_NB          = 4;
   localparam int unsigned AES_STATE_BYTES = 16;

   // State is column-major: byte index of s[row][col].
   function automatic int unsigned byte_idx(input int unsigned row, input int unsigned col);
      return AES_NB * col + row;
   endfunction

endpackage

// File: rtl/shift_rows_core.sv
// Combinational ShiftRows (INVERSE=0) / InvShiftRows (INVERSE=1) byte permutation.
module shift_rows_core
   import aes_pkg::*;
#(
   parameter int INVERSE = 0
) (
   input  logic [127:0] input_state,
   output logic [127:0] output_state
);

   if (INVERSE != 0 && INVERSE != 1) begin : g_bad_inverse
      $error("shift_rows_core: INVERSE must be 0 or 1");
   end

   for (genvar r = 0; r < AES_NB; r++) begin : g_row
      for (genvar c = 0; c < AES_NB; c++) begin : g_col
         // Forward rotates row r left by r; inverse rotates it right by r.
         localparam int unsigned SRC_COL = (INVERSE == 0) ? ((c + r) % AES_NB)
                                                          : ((c + AES_NB - r) % AES_NB);
         localparam int unsigned DST = byte_idx(r, c);
         localparam int unsigned SRC = byte_idx(r, SRC_COL);
         assign output_state[127 - 8*DST -: 8] = input_state[127 - 8*SRC -: 8];
      end
   end

endmodule

// File: rtl/shift_rows.sv
// Registered AES ShiftRows/InvShiftRows stage, 1-cycle latency, no backpressure.
// Optional per-byte even parity output enabled by defining SHIFT_ROWS_PARITY_EN.
module shift_rows
   import aes_pkg::*;
#(
   parameter int INVERSE = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [127:0] input_state,
   output logic         out_valid,
`ifdef SHIFT_ROWS_PARITY_EN
   output logic [127:0] output_state,
   output logic [15:0]  out_parity
`else
   output logic [127:0] output_state
`endif
);

   logic [127:0] w_perm;
   logic         r_valid;
   logic [127:0] r_state;

   shift_rows_core #(.INVERSE(INVERSE)) u_core (
      .input_state  (input_state),
      .output_state (w_perm)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_state <= '0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_state <= w_perm;
         end
      end
   end

   assign out_valid    = r_valid;
   assign output_state = r_state;

`ifdef SHIFT_ROWS_PARITY_EN
   logic [15:0] w_parity;
   logic [15:0] r_parity;

   for (genvar k = 0; k < AES_STATE_BYTES; k++) begin : g_par
      assign w_parity[k] = ^w_perm[127 - 8*k -: 8];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_parity <= '0;
      end else if (in_valid) begin
         r_parity <= w_parity;
      end
   end

   assign out_parity = r_parity;
`endif

endmodule

// File: tb/tb_shift_rows.sv
// Scoreboard bench for shift_rows: forward, inverse and chained round-trip instances.
// Define SHIFT_ROWS_PARITY_EN to also exercise the parity output.
module tb_shift_rows;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [127:0] din;

   logic         ov_f, ov_i, ov_fi, ov_if;
   logic [127:0] os_f, os_i, os_fi, os_if;
`ifdef SHIFT_ROWS_PARITY_EN
   logic [15:0]  p_f, p_i, p_fi, p_if;
`endif

   int checks   = 0;
   int failures = 0;

   logic [127:0] q_f[$], q_i[$], q_fi[$], q_if[$];

   always #5 clk = ~clk;

   shift_rows #(.INVERSE(0)) u_fwd (
      .clk(clk), .rst(rst), .in_valid(in_valid), .input_state(din),
`ifdef SHIFT_ROWS_PARITY_EN
      .out_parity(p_f),
`endif
      .out_valid(ov_f), .output_state(os_f));

   shift_rows #(.INVERSE(1)) u_inv (
      .clk(clk), .rst(rst), .in_valid(in_valid), .input_state(din),
`ifdef SHIFT_ROWS_PARITY_EN
      .out_parity(p_i),
`endif
      .out_valid(ov_i), .output_state(os_i));

   shift_rows #(.INVERSE(1)) u_fi (
      .clk(clk), .rst(rst), .in_valid(ov_f), .input_state(os_f),
`ifdef SHIFT_ROWS_PARITY_EN
      .out_parity(p_fi),
`endif
      .out_valid(ov_fi), .output_state(os_fi));

   shift_rows #(.INVERSE(0)) u_if (
      .clk(clk), .rst(rst), .in_valid(ov_i), .input_state(os_i),
`ifdef SHIFT_ROWS_PARITY_EN
      .out_parity(p_if),
`endif
      .out_valid(ov_if), .output_state(os_if));

   // Reference model: unpack to s[row][col], rotate each row one step at a time.
   function automatic logic [127:0] ref_shift(input logic [127:0] x, input bit inv);
      logic [7:0]   m [4][4];
      logic [7:0]   t;
      logic [127:0] y;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            m[r][c] = x[127 - 8*(4*c + r) -: 8];
      for (int r = 0; r < 4; r++) begin
         for (int n = 0; n < r; n++) begin
            if (!inv) begin
               t = m[r][0]; m[r][0] = m[r][1]; m[r][1] = m[r][2]; m[r][2] = m[r][3]; m[r][3] = t;
            end else begin
               t = m[r][3]; m[r][3] = m[r][2]; m[r][2] = m[r][1]; m[r][1] = m[r][0]; m[r][0] = t;
            end
         end
      end
      y = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            y = {y[119:0], m[r][c]};
      return y;
   endfunction

   function automatic logic [15:0] ref_parity(input logic [127:0] x);
      logic [15:0]  p;
      logic [127:0] t;
      p = '0;
      for (int k = 0; k < 16; k++) begin
         t = x << (8*k);
         p[k] = ^t[127:120];
      end
      return p;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [127:0] d, input logic [127:0] ef, input logic [127:0] ei);
      @(negedge clk);
      in_valid = 1'b1;
      din      = d;
      q_f.push_back(ef);
      q_i.push_back(ei);
      q_fi.push_back(d);
      q_if.push_back(d);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Scoreboard: every out_valid pulse pops one expected value; an empty queue yields X and fails.
   always @(negedge clk) begin
      logic [127:0] e;
      if (!rst) begin
         if (ov_f)  begin e = (q_f.size()  > 0) ? q_f.pop_front()  : 'x; chk("fwd", os_f, e);  end
         if (ov_i)  begin e = (q_i.size()  > 0) ? q_i.pop_front()  : 'x; chk("inv", os_i, e);  end
         if (ov_fi) begin e = (q_fi.size() > 0) ? q_fi.pop_front() : 'x; chk("fwd_inv", os_fi, e); end
         if (ov_if) begin e = (q_if.size() > 0) ? q_if.pop_front() : 'x; chk("inv_fwd", os_if, e); end
      end
   end

   initial begin
      logic [127:0] fips_in, fips_out, a, b, c, w;
      fips_in  = 128'hd42711aee0bf98f1b8b45de51e415230;
      fips_out = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
      a = 128'h00112233445566778899aabbccddeeff;
      b = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
      c = 128'h3243f6a8885a308d313198a2e0370734;

      rst = 1'b1; in_valid = 1'b0; din = '0;
      repeat (2) @(negedge clk);
      chk1("reset_valid_fwd", ov_f, 1'b0);
      chk("reset_state_fwd", os_f, '0);
      chk1("reset_valid_inv", ov_i, 1'b0);
      chk("reset_state_inv", os_i, '0);
      rst = 1'b0;

      drive(fips_in, fips_out, ref_shift(fips_in, 1'b1));
      drive(fips_out, ref_shift(fips_out, 1'b0), fips_in);
      drive('0, '0, '0);
      drive('1, '1, '1);
      drive({16{8'hA5}}, {16{8'hA5}}, {16{8'hA5}});
      drive({16{8'h5A}}, {16{8'h5A}}, {16{8'h5A}});
      idle(); idle(); idle();

      // Streaming then hold.
      drive(a, ref_shift(a, 1'b0), ref_shift(a, 1'b1));
      drive(b, ref_shift(b, 1'b0), ref_shift(b, 1'b1));
      chk1("stream_v1", ov_f, 1'b1);
      drive(c, ref_shift(c, 1'b0), ref_shift(c, 1'b1));
      chk1("stream_v2", ov_f, 1'b1);
      idle();
      chk1("stream_v3", ov_f, 1'b1);
      idle();
      chk1("stream_drop", ov_f, 1'b0);
      chk("hold_fwd", os_f, ref_shift(c, 1'b0));
      chk("hold_inv", os_i, ref_shift(c, 1'b1));
      idle();
      chk("hold_fwd2", os_f, ref_shift(c, 1'b0));

      for (int i = 0; i < 128; i++) begin
         w = 128'd1 << i;
         drive(w, ref_shift(w, 1'b0), ref_shift(w, 1'b1));
      end
      for (int i = 0; i < 100; i++) begin
         w = {$urandom, $urandom, $urandom, $urandom};
         drive(w, ref_shift(w, 1'b0), ref_shift(w, 1'b1));
      end
      idle(); idle(); idle();

      // Asynchronous reset between edges while a result is valid.
      drive(a, ref_shift(a, 1'b0), ref_shift(a, 1'b1));
      @(posedge clk);
      #2;
      chk1("pre_reset_valid", ov_f, 1'b1);
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      chk1("async_reset_valid_fwd", ov_f, 1'b0);
      chk("async_reset_state_fwd", os_f, '0);
      chk1("async_reset_valid_inv", ov_i, 1'b0);
      chk("async_reset_state_inv", os_i, '0);
`ifdef SHIFT_ROWS_PARITY_EN
      chk("async_reset_parity", {112'b0, p_f}, '0);
`endif
      q_f.delete(); q_i.delete(); q_fi.delete(); q_if.delete();
      @(negedge clk);
      rst = 1'b0;
      drive(fips_in, fips_out, ref_shift(fips_in, 1'b1));
      idle();
      chk1("post_reset_capture", ov_f, 1'b1);
`ifdef SHIFT_ROWS_PARITY_EN
      chk1("parity_byte0", p_f[0], 1'b0);
      chk("parity_fwd", {112'b0, p_f}, {112'b0, ref_parity(fips_out)});
      chk("parity_inv", {112'b0, p_i}, {112'b0, ref_parity(ref_shift(fips_in, 1'b1))});
`endif

      for (int n = 0; n < 10; n++) begin
         if (q_f.size() == 0 && q_i.size() == 0 && q_fi.size() == 0 && q_if.size() == 0) break;
         idle();
      end
      chk("drain_fwd", 128'(q_f.size()), '0);
      chk("drain_inv", 128'(q_i.size()), '0);
      chk("drain_fwd_inv", 128'(q_fi.size()), '0);
      chk("drain_inv_fwd", 128'(q_if.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
